// File: rtl/charge_trigger.sv
// Request front-end for the charge fanfare player: debounced button plus tour-complete
// requests, a 3-deep request counter, and a go/lockout sequencer.
module charge_trigger #(
  parameter int unsigned FAST_SIM    = 1,
  parameter int unsigned DB_CYC      = 1000000,
  parameter int unsigned LOCKOUT_CYC = 58720256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       tour_done,
  input  logic       mute,
  output logic       go,
  output logic       busy,
  output logic [1:0] pend,
  output logic       req_drop
);

  localparam int unsigned STEP = (FAST_SIM != 0) ? 16 : 1;
  localparam logic [19:0] DB_LIM  = 20'(DB_CYC);
  localparam logic [19:0] DB_STEP = 20'(STEP);
  localparam logic [25:0] LK_LIM  = 26'(LOCKOUT_CYC);
  localparam logic [25:0] LK_STEP = 26'(STEP);

  typedef enum logic {IDLE, LOCK} state_e;

  logic        sync1_q, sync2_q;
  logic        db_lvl_q, db_lvl_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        press_q, press_d;
  logic [1:0]  pend_q, pend_d;
  logic        drop_q, drop_d;
  state_e      state_q, state_d;
  logic [25:0] lk_cnt_q, lk_cnt_d;
  logic        go_q, go_d;
  logic        fire;
  logic [1:0]  req_n;
  logic [2:0]  sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_lvl_q <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      pend_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
    end
  end

  // Debounce: the synced level must disagree with db_lvl for DB_CYC before it is adopted.
  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == db_lvl_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q >= DB_LIM) begin
      db_lvl_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_STEP;
    end
    press_d = db_lvl_q & ~db_lvl_d;
  end

  assign fire = (state_q == IDLE) && (pend_q != 2'd0) && !mute;

  // fire implies pend >= 1, so the sum never underflows.
  always_comb begin
    req_n = {1'b0, press_q} + {1'b0, tour_done};
    sum   = {1'b0, pend_q} + {1'b0, req_n} - {2'b00, fire};
    if (mute) begin
      pend_d = '0;
      drop_d = 1'b0;
    end else begin
      drop_d = (sum > 3'd3);
      pend_d = drop_d ? 2'd3 : sum[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lk_cnt_q <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lk_cnt_q <= lk_cnt_d;
      go_q     <= go_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lk_cnt_d = lk_cnt_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d  = LOCK;
          lk_cnt_d = '0;
        end
      end
      LOCK: begin
        if (lk_cnt_q >= LK_LIM) state_d = IDLE;
        else                    lk_cnt_d = lk_cnt_q + LK_STEP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    go_d = fire;
  end

  assign go       = go_q;
  assign busy     = (state_q == LOCK);
  assign pend     = pend_q;
  assign req_drop = drop_q;

endmodule
